atm: RTL and testbench

Single-clock ATM session controller: accepts a card (account number), language choice and PIN, then runs one or more transactions (balance, withdraw, deposit, transfer, PIN change) against an internal 4-entry account table. Each completed step is reported on a one-cycle success flag. It sits between the front-panel input logic (keypad, card reader, cash counter, timer) and the display/printer status logic.

---
 rtl/atm_pkg.sv | 51 +++++
 rtl/atm_account_table.sv | 91 +++++++++
 rtl/atm.sv | 267 ++++++++++++++++++++++++++
 tb/tb_atm.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// atm_pkg
// Shared definitions for the ATM session controller: field widths, the
// session state enum, the transaction opcodes and the power-on contents of
// the account table (account numbers, PINs and balances).
package atm_pkg;

    localparam int ACCT_W = 17;
    localparam int PIN_W  = 17;
    localparam int AMT_W  = 19;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LANG,
        ST_PIN,
        ST_MENU,
        ST_BALANCE,
        ST_WITHDRAW,
        ST_DEPOSIT,
        ST_TRANSFER,
        ST_CHG_PIN,
        ST_RECEIPT,
        ST_ANOTHER,
        ST_FINISH
    } atm_state_e;

    localparam logic [2:0] OP_BALANCE  = 3'b000;
    localparam logic [2:0] OP_WITHDRAW = 3'b001;
    localparam logic [2:0] OP_DEPOSIT  = 3'b010;
    localparam logic [2:0] OP_TRANSFER = 3'b011;
    localparam logic [2:0] OP_CHG_PIN  = 3'b100;

    // Account numbers are fixed at 1001, 1002, ... and never rewritten.
    function automatic logic [ACCT_W-1:0] default_acct_no(input int idx);
        return ACCT_W'(1001 + idx);
    endfunction

    function automatic logic [PIN_W-1:0] default_pin(input int idx);
        return PIN_W'(1111 * ((idx % 4) + 1));
    endfunction

    function automatic logic [AMT_W-1:0] default_balance(input int idx);
        case (idx)
            0:       return AMT_W'(5000);
            1:       return AMT_W'(10000);
            2:       return AMT_W'(0);
            3:       return AMT_W'(500000);
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/atm_account_table.sv
// atm_account_table
// Holds the per-account PIN and balance. Account numbers are constants.
// Ports:
//   clk, reset        clock and asynchronous active-low reset (reloads defaults)
//   a_acct_no         own-account lookup key -> a_hit, a_idx, a_pin, a_bal
//   b_acct_no         destination lookup key -> b_hit, b_idx, b_bal
//   bal_a_*           balance write port A (enable, index, data)
//   bal_b_*           balance write port B (enable, index, data)
//   pin_*             PIN write port (enable, index, data)
module atm_account_table
    import atm_pkg::*;
#(
    parameter int NUM_ACCOUNTS = 4,
    parameter int IDX_W        = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ACCT_W-1:0] a_acct_no,
    output logic              a_hit,
    output logic [IDX_W-1:0]  a_idx,
    output logic [PIN_W-1:0]  a_pin,
    output logic [AMT_W-1:0]  a_bal,
    input  logic [ACCT_W-1:0] b_acct_no,
    output logic              b_hit,
    output logic [IDX_W-1:0]  b_idx,
    output logic [AMT_W-1:0]  b_bal,
    input  logic              bal_a_we,
    input  logic [IDX_W-1:0]  bal_a_idx,
    input  logic [AMT_W-1:0]  bal_a_data,
    input  logic              bal_b_we,
    input  logic [IDX_W-1:0]  bal_b_idx,
    input  logic [AMT_W-1:0]  bal_b_data,
    input  logic              pin_we,
    input  logic [IDX_W-1:0]  pin_idx,
    input  logic [PIN_W-1:0]  pin_data
);

    logic [PIN_W-1:0] pin_q [NUM_ACCOUNTS];
    logic [PIN_W-1:0] pin_d [NUM_ACCOUNTS];
    logic [AMT_W-1:0] bal_q [NUM_ACCOUNTS];
    logic [AMT_W-1:0] bal_d [NUM_ACCOUNTS];

    // First matching entry wins; account numbers are unique anyway.
    always_comb begin
        a_hit = 1'b0;
        a_idx = '0;
        for (int i = 0; i < NUM_ACCOUNTS; i++) begin
            if (!a_hit && default_acct_no(i) == a_acct_no) begin
                a_hit = 1'b1;
                a_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        b_hit = 1'b0;
        b_idx = '0;
        for (int i = 0; i < NUM_ACCOUNTS; i++) begin
            if (!b_hit && default_acct_no(i) == b_acct_no) begin
                b_hit = 1'b1;
                b_idx = IDX_W'(i);
            end
        end
    end

    assign a_pin = pin_q[a_idx];
    assign a_bal = bal_q[a_idx];
    assign b_bal = bal_q[b_idx];

    // The controller never aims both balance ports at one entry.
    always_comb begin
        pin_d = pin_q;
        bal_d = bal_q;
        if (bal_a_we) bal_d[bal_a_idx] = bal_a_data;
        if (bal_b_we) bal_d[bal_b_idx] = bal_b_data;
        if (pin_we)   pin_d[pin_idx]   = pin_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ACCOUNTS; i++) begin
                pin_q[i] <= default_pin(i);
                bal_q[i] <= default_balance(i);
            end
        end else begin
            pin_q <= pin_d;
            bal_q <= bal_d;
        end
    end

endmodule

// File: rtl/atm.sv
// atm
// ATM session controller: card lookup, language latch, PIN check with a
// limited number of tries, then a menu of transactions against the account
// table. Every success indication is a registered one-cycle pulse.
// Ports:
//   clk, reset                      clock, asynchronous active-low reset
//   Card_in, Language, Timer        front-panel status
//   money_counting                  deposit cash still being counted
//   another_transaction_bit         return to menu after a transaction
//   opcode                          transaction selector
//   password, new_pin               entered and replacement PIN
//   allowwithdraw, allow_transfer,
//   take_receipt                    user confirmations
//   Pers_Account_No, ur_account     own and destination account numbers
//   withdraw_amount, Transfer_Amount,
//   deposit_amount                  unsigned amounts
//   *_Successfully, Balance_Shown,
//   Receipt_Printed                 one-cycle success pulses
//   ATM_Usage_Finished              high while the session is in FINISH
module atm
    import atm_pkg::*;
#(
    parameter int NUM_ACCOUNTS  = 4,
    parameter int MAX_PIN_TRIES = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Card_in,
    input  logic              Language,
    input  logic              Timer,
    input  logic              money_counting,
    input  logic              another_transaction_bit,
    input  logic [2:0]        opcode,
    input  logic [PIN_W-1:0]  password,
    input  logic [PIN_W-1:0]  new_pin,
    input  logic              allowwithdraw,
    input  logic              allow_transfer,
    input  logic              take_receipt,
    input  logic [ACCT_W-1:0] Pers_Account_No,
    input  logic [ACCT_W-1:0] ur_account,
    input  logic [AMT_W-1:0]  withdraw_amount,
    input  logic [AMT_W-1:0]  Transfer_Amount,
    input  logic [AMT_W-1:0]  deposit_amount,
    output logic              Transfer_Successfully,
    output logic              Balance_Shown,
    output logic              Deposited_Successfully,
    output logic              Withdrew_Successfully,
    output logic              Pin_Changed_Successfully,
    output logic              Receipt_Printed,
    output logic              ATM_Usage_Finished
);

    localparam int IDX_W = (NUM_ACCOUNTS > 1) ? $clog2(NUM_ACCOUNTS) : 1;
    localparam int TRY_W = $clog2(MAX_PIN_TRIES + 1);

    atm_state_e        state_q, state_d;
    logic [TRY_W-1:0]  tries_q, tries_d;
    logic [ACCT_W-1:0] acct_q, acct_d;
    logic              lang_unused_q, lang_unused_d;
    logic              transfer_ok_q, transfer_ok_d;
    logic              balance_shown_q, balance_shown_d;
    logic              deposited_q, deposited_d;
    logic              withdrew_q, withdrew_d;
    logic              pin_changed_q, pin_changed_d;
    logic              receipt_q, receipt_d;
    logic              finished_q, finished_d;

    logic [ACCT_W-1:0] own_lookup;
    logic              own_hit, dst_hit;
    logic [IDX_W-1:0]  own_idx, dst_idx;
    logic [PIN_W-1:0]  own_pin;
    logic [AMT_W-1:0]  own_bal, dst_bal;

    logic              bal_a_we, bal_b_we, pin_we;
    logic [AMT_W-1:0]  bal_a_data, bal_b_data;

    logic [AMT_W:0]    dep_sum, xfer_sum;
    logic              abort;

    // In IDLE the card's account number is looked up; afterwards the
    // latched number keeps pointing at the session's own entry.
    assign own_lookup = (state_q == ST_IDLE) ? Pers_Account_No : acct_q;

    atm_account_table #(
        .NUM_ACCOUNTS (NUM_ACCOUNTS),
        .IDX_W        (IDX_W)
    ) u_table (
        .clk        (clk),
        .reset      (reset),
        .a_acct_no  (own_lookup),
        .a_hit      (own_hit),
        .a_idx      (own_idx),
        .a_pin      (own_pin),
        .a_bal      (own_bal),
        .b_acct_no  (ur_account),
        .b_hit      (dst_hit),
        .b_idx      (dst_idx),
        .b_bal      (dst_bal),
        .bal_a_we   (bal_a_we),
        .bal_a_idx  (own_idx),
        .bal_a_data (bal_a_data),
        .bal_b_we   (bal_b_we),
        .bal_b_idx  (dst_idx),
        .bal_b_data (bal_b_data),
        .pin_we     (pin_we),
        .pin_idx    (own_idx),
        .pin_data   (new_pin)
    );

    // One extra bit catches any sum that would not fit the balance width.
    assign dep_sum  = {1'b0, own_bal} + {1'b0, deposit_amount};
    assign xfer_sum = {1'b0, dst_bal} + {1'b0, Transfer_Amount};

    assign abort = (state_q != ST_IDLE) && (state_q != ST_FINISH) &&
                   (Timer || !Card_in);

    always_comb begin
        state_d         = state_q;
        tries_d         = tries_q;
        acct_d          = acct_q;
        lang_unused_d   = lang_unused_q;
        transfer_ok_d   = 1'b0;
        balance_shown_d = 1'b0;
        deposited_d     = 1'b0;
        withdrew_d      = 1'b0;
        pin_changed_d   = 1'b0;
        receipt_d       = 1'b0;
        bal_a_we        = 1'b0;
        bal_b_we        = 1'b0;
        pin_we          = 1'b0;
        bal_a_data      = own_bal;
        bal_b_data      = dst_bal;

        // A timeout or pulled card wins over everything the state would do.
        if (abort) begin
            state_d = ST_FINISH;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tries_d = '0;
                    if (Card_in && own_hit) begin
                        acct_d  = Pers_Account_No;
                        state_d = ST_LANG;
                    end
                end
                ST_LANG: begin
                    lang_unused_d = Language;
                    state_d       = ST_PIN;
                end
                ST_PIN: begin
                    if (password == own_pin) begin
                        tries_d = '0;
                        state_d = ST_MENU;
                    end else begin
                        tries_d = tries_q + 1'b1;
                        if (tries_q == TRY_W'(MAX_PIN_TRIES - 1)) begin
                            state_d = ST_FINISH;
                        end
                    end
                end
                ST_MENU: begin
                    case (opcode)
                        OP_BALANCE:  state_d = ST_BALANCE;
                        OP_WITHDRAW: state_d = ST_WITHDRAW;
                        OP_DEPOSIT:  state_d = ST_DEPOSIT;
                        OP_TRANSFER: state_d = ST_TRANSFER;
                        OP_CHG_PIN:  state_d = ST_CHG_PIN;
                        default:     state_d = ST_MENU;
                    endcase
                end
                ST_BALANCE: begin
                    balance_shown_d = 1'b1;
                    state_d         = ST_RECEIPT;
                end
                ST_WITHDRAW: begin
                    if (allowwithdraw && withdraw_amount != '0 &&
                        withdraw_amount <= own_bal) begin
                        bal_a_we   = 1'b1;
                        bal_a_data = own_bal - withdraw_amount;
                        withdrew_d = 1'b1;
                    end
                    state_d = ST_RECEIPT;
                end
                ST_DEPOSIT: begin
                    if (!money_counting) begin
                        if (deposit_amount != '0 && !dep_sum[AMT_W]) begin
                            bal_a_we    = 1'b1;
                            bal_a_data  = dep_sum[AMT_W-1:0];
                            deposited_d = 1'b1;
                        end
                        state_d = ST_RECEIPT;
                    end
                end
                ST_TRANSFER: begin
                    if (allow_transfer && dst_hit && ur_account != acct_q &&
                        Transfer_Amount != '0 && Transfer_Amount <= own_bal &&
                        !xfer_sum[AMT_W]) begin
                        bal_a_we      = 1'b1;
                        bal_a_data    = own_bal - Transfer_Amount;
                        bal_b_we      = 1'b1;
                        bal_b_data    = xfer_sum[AMT_W-1:0];
                        transfer_ok_d = 1'b1;
                    end
                    state_d = ST_RECEIPT;
                end
                ST_CHG_PIN: begin
                    if (new_pin != own_pin) begin
                        pin_we        = 1'b1;
                        pin_changed_d = 1'b1;
                    end
                    state_d = ST_RECEIPT;
                end
                ST_RECEIPT: begin
                    receipt_d = take_receipt;
                    state_d   = ST_ANOTHER;
                end
                ST_ANOTHER: begin
                    state_d = another_transaction_bit ? ST_MENU : ST_FINISH;
                end
                ST_FINISH: begin
                    if (!Card_in) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Registered from the next state so the flag tracks FINISH exactly.
        finished_d = (state_d == ST_FINISH);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            tries_q         <= '0;
            acct_q          <= '0;
            lang_unused_q   <= 1'b0;
            transfer_ok_q   <= 1'b0;
            balance_shown_q <= 1'b0;
            deposited_q     <= 1'b0;
            withdrew_q      <= 1'b0;
            pin_changed_q   <= 1'b0;
            receipt_q       <= 1'b0;
            finished_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            tries_q         <= tries_d;
            acct_q          <= acct_d;
            lang_unused_q   <= lang_unused_d;
            transfer_ok_q   <= transfer_ok_d;
            balance_shown_q <= balance_shown_d;
            deposited_q     <= deposited_d;
            withdrew_q      <= withdrew_d;
            pin_changed_q   <= pin_changed_d;
            receipt_q       <= receipt_d;
            finished_q      <= finished_d;
        end
    end

    assign Transfer_Successfully    = transfer_ok_q;
    assign Balance_Shown            = balance_shown_q;
    assign Deposited_Successfully   = deposited_q;
    assign Withdrew_Successfully    = withdrew_q;
    assign Pin_Changed_Successfully = pin_changed_q;
    assign Receipt_Printed          = receipt_q;
    assign ATM_Usage_Finished       = finished_q;

endmodule

// File: tb/tb_atm.sv
// tb_atm
// Directed sessions against the ATM controller. A session-level reference
// model tracks balances, PINs and where the session is, and every cycle its
// expected outputs are compared with the DUT. Literal checks pin the model.
module tb_atm;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Card_in = 1'b0;
    logic        Language = 1'b0;
    logic        Timer = 1'b0;
    logic        money_counting = 1'b0;
    logic        another_transaction_bit = 1'b0;
    logic [2:0]  opcode = 3'b000;
    logic [16:0] password = '0;
    logic [16:0] new_pin = '0;
    logic        allowwithdraw = 1'b0;
    logic        allow_transfer = 1'b0;
    logic        take_receipt = 1'b1;
    logic [16:0] Pers_Account_No = '0;
    logic [16:0] ur_account = '0;
    logic [18:0] withdraw_amount = '0;
    logic [18:0] Transfer_Amount = '0;
    logic [18:0] deposit_amount = '0;
    logic        Transfer_Successfully, Balance_Shown, Deposited_Successfully;
    logic        Withdrew_Successfully, Pin_Changed_Successfully, Receipt_Printed;
    logic        ATM_Usage_Finished;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int cnt_bal = 0, cnt_wd = 0, cnt_dep = 0, cnt_tr = 0, cnt_pin = 0, cnt_rcpt = 0;
    int first_bal_cyc = -1;

    atm dut (
        .clk                      (clk),
        .reset                    (reset),
        .Card_in                  (Card_in),
        .Language                 (Language),
        .Timer                    (Timer),
        .money_counting           (money_counting),
        .another_transaction_bit  (another_transaction_bit),
        .opcode                   (opcode),
        .password                 (password),
        .new_pin                  (new_pin),
        .allowwithdraw            (allowwithdraw),
        .allow_transfer           (allow_transfer),
        .take_receipt             (take_receipt),
        .Pers_Account_No          (Pers_Account_No),
        .ur_account               (ur_account),
        .withdraw_amount          (withdraw_amount),
        .Transfer_Amount          (Transfer_Amount),
        .deposit_amount           (deposit_amount),
        .Transfer_Successfully    (Transfer_Successfully),
        .Balance_Shown            (Balance_Shown),
        .Deposited_Successfully   (Deposited_Successfully),
        .Withdrew_Successfully    (Withdrew_Successfully),
        .Pin_Changed_Successfully (Pin_Changed_Successfully),
        .Receipt_Printed          (Receipt_Printed),
        .ATM_Usage_Finished       (ATM_Usage_Finished)
    );

    always #5 clk = ~clk;

    // Reference model: where the session is, what the table holds, and the
    // outputs the controller must show after the current edge.
    localparam int MAX_AMT = 524287;
    int    m_acct [4];
    int    m_pin  [4];
    int    m_bal  [4];
    string m_st;
    int    m_own;
    int    m_tries;
    logic [6:0] exp_out;

    function automatic int find_acct(input int acct);
        for (int i = 0; i < 4; i++) if (m_acct[i] == acct) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_acct  = '{1001, 1002, 1003, 1004};
        m_pin   = '{1111, 2222, 3333, 4444};
        m_bal   = '{5000, 10000, 0, 500000};
        m_st    = "IDLE";
        m_own   = 0;
        m_tries = 0;
        exp_out = '0;
    endtask

    task automatic model_step();
        string nxt;
        int d;
        int amt;
        logic tr, bs, dp, wd, pc, rp;
        tr = 0; bs = 0; dp = 0; wd = 0; pc = 0; rp = 0;
        nxt = m_st;
        if (m_st != "IDLE" && m_st != "FINISH" && (Timer || !Card_in)) begin
            nxt = "FINISH";
        end else if (m_st == "IDLE") begin
            if (Card_in) begin
                d = find_acct(int'(Pers_Account_No));
                if (d >= 0) begin
                    m_own = d; m_tries = 0; nxt = "LANG";
                end
            end
        end else if (m_st == "LANG") begin
            nxt = "PIN";
        end else if (m_st == "PIN") begin
            if (int'(password) == m_pin[m_own]) begin
                m_tries = 0; nxt = "MENU";
            end else begin
                m_tries++;
                if (m_tries >= 3) nxt = "FINISH";
            end
        end else if (m_st == "MENU") begin
            if (opcode == 3'd0) nxt = "BALANCE";
            else if (opcode == 3'd1) nxt = "WITHDRAW";
            else if (opcode == 3'd2) nxt = "DEPOSIT";
            else if (opcode == 3'd3) nxt = "TRANSFER";
            else if (opcode == 3'd4) nxt = "CHG_PIN";
        end else if (m_st == "BALANCE") begin
            bs = 1; nxt = "RECEIPT";
        end else if (m_st == "WITHDRAW") begin
            amt = int'(withdraw_amount);
            if (allowwithdraw && amt != 0 && amt <= m_bal[m_own]) begin
                m_bal[m_own] -= amt; wd = 1;
            end
            nxt = "RECEIPT";
        end else if (m_st == "DEPOSIT") begin
            if (!money_counting) begin
                amt = int'(deposit_amount);
                if (amt != 0 && m_bal[m_own] + amt <= MAX_AMT) begin
                    m_bal[m_own] += amt; dp = 1;
                end
                nxt = "RECEIPT";
            end
        end else if (m_st == "TRANSFER") begin
            amt = int'(Transfer_Amount);
            d = find_acct(int'(ur_account));
            if (allow_transfer && d >= 0 && d != m_own && amt != 0 &&
                amt <= m_bal[m_own] && m_bal[d] + amt <= MAX_AMT) begin
                m_bal[m_own] -= amt; m_bal[d] += amt; tr = 1;
            end
            nxt = "RECEIPT";
        end else if (m_st == "CHG_PIN") begin
            if (int'(new_pin) != m_pin[m_own]) begin
                m_pin[m_own] = int'(new_pin); pc = 1;
            end
            nxt = "RECEIPT";
        end else if (m_st == "RECEIPT") begin
            rp = take_receipt; nxt = "ANOTHER";
        end else if (m_st == "ANOTHER") begin
            nxt = another_transaction_bit ? "MENU" : "FINISH";
        end else if (m_st == "FINISH") begin
            if (!Card_in) nxt = "IDLE";
        end
        m_st = nxt;
        exp_out = {tr, bs, dp, wd, pc, rp, (m_st == "FINISH")};
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) model_reset();
        else begin
            cyc++;
            model_step();
        end
    end

    // Every cycle, away from the active edge, the DUT must match the model.
    always @(negedge clk) begin
        logic [6:0] act;
        act = {Transfer_Successfully, Balance_Shown, Deposited_Successfully,
               Withdrew_Successfully, Pin_Changed_Successfully, Receipt_Printed,
               ATM_Usage_Finished};
        vectors++;
        if (act !== exp_out) begin
            miscompares++;
            $display("[TB] FAIL outputs cyc=%0d state=%s actual=%b required=%b",
                     cyc, m_st, act, exp_out);
        end
        if (Balance_Shown) begin
            cnt_bal++;
            if (first_bal_cyc < 0) first_bal_cyc = cyc;
        end
        if (Withdrew_Successfully)    cnt_wd++;
        if (Deposited_Successfully)   cnt_dep++;
        if (Transfer_Successfully)    cnt_tr++;
        if (Pin_Changed_Successfully) cnt_pin++;
        if (Receipt_Printed)          cnt_rcpt++;
    end

    task automatic check_output(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    // Insert the card and get through LANG and the PIN check.
    task automatic apply_stimulus(input int acct, input int pin);
        Card_in = 1'b1;
        Timer = 1'b0;
        Pers_Account_No = 17'(acct);
        password = 17'(pin);
        repeat (3) @(negedge clk);
    endtask

    // One menu round: MENU, the operation (with optional counting wait),
    // RECEIPT and ANOTHER.
    task automatic run_txn(input logic [2:0] op, input logic another, input int count_cycles);
        opcode = op;
        another_transaction_bit = another;
        money_counting = (count_cycles > 0);
        @(negedge clk);
        repeat (count_cycles) @(negedge clk);
        money_counting = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic end_session();
        Card_in = 1'b0;
        Timer = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int c0;
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Balance enquiry on 1001, with the minimum card-to-display latency.
        c0 = cyc;
        apply_stimulus(1001, 1111);
        run_txn(3'b000, 1'b0, 0);
        repeat (2) @(negedge clk);
        check_output("finish_held", int'(ATM_Usage_Finished), 1);
        end_session();
        check_output("balance_latency", first_bal_cyc - c0, 5);
        check_output("balance_pulses", cnt_bal, 1);
        check_output("receipt_pulses", cnt_rcpt, 1);

        // Over-limit withdrawal rejected, then 2000 accepted.
        allowwithdraw = 1'b1;
        apply_stimulus(1001, 1111);
        withdraw_amount = 19'd6000;
        run_txn(3'b001, 1'b1, 0);
        withdraw_amount = 19'd2000;
        run_txn(3'b001, 1'b1, 0);
        run_txn(3'b000, 1'b0, 0);
        end_session();
        check_output("withdraw_pulses", cnt_wd, 1);
        check_output("model_bal_1001", m_bal[0], 3000);
        check_output("dut_bal_1001", int'(dut.u_table.bal_q[0]), 3000);

        // Three wrong PINs end the session.
        apply_stimulus(1001, 0);
        repeat (3) @(negedge clk);
        check_output("pin_lockout_fin", int'(ATM_Usage_Finished), 1);
        end_session();

        // Timeout while cash is still being counted.
        apply_stimulus(1002, 2222);
        opcode = 3'b010;
        deposit_amount = 19'd100;
        money_counting = 1'b1;
        repeat (3) @(negedge clk);
        Timer = 1'b1;
        @(negedge clk);
        Timer = 1'b0;
        money_counting = 1'b0;
        check_output("timeout_fin", int'(ATM_Usage_Finished), 1);
        end_session();
        check_output("dut_bal_1002_timeout", int'(dut.u_table.bal_q[1]), 10000);

        // Transfer 1002 -> 1003, then a self-transfer that must be refused.
        allow_transfer = 1'b1;
        Transfer_Amount = 19'd1000;
        apply_stimulus(1002, 2222);
        ur_account = 17'd1003;
        run_txn(3'b011, 1'b1, 0);
        ur_account = 17'd1002;
        run_txn(3'b011, 1'b0, 0);
        end_session();
        check_output("transfer_pulses", cnt_tr, 1);
        check_output("dut_bal_1002", int'(dut.u_table.bal_q[1]), 9000);
        check_output("dut_bal_1003", int'(dut.u_table.bal_q[2]), 1000);

        // Unused opcode parks in MENU; then a counted deposit.
        apply_stimulus(1003, 3333);
        opcode = 3'b101;
        repeat (2) @(negedge clk);
        deposit_amount = 19'd500;
        run_txn(3'b010, 1'b0, 2);
        end_session();
        check_output("dut_bal_1003_dep", int'(dut.u_table.bal_q[2]), 1500);

        // Deposits at the top of the balance range.
        apply_stimulus(1004, 4444);
        deposit_amount = 19'd30000;
        run_txn(3'b010, 1'b1, 0);
        deposit_amount = 19'd24287;
        run_txn(3'b010, 1'b0, 0);
        end_session();
        check_output("deposit_pulses", cnt_dep, 2);
        check_output("dut_bal_1004", int'(dut.u_table.bal_q[3]), 524287);

        // PIN change, then old PIN refused and new PIN accepted.
        apply_stimulus(1001, 1111);
        new_pin = 17'd4242;
        run_txn(3'b100, 1'b0, 0);
        end_session();
        check_output("pin_change_pulses", cnt_pin, 1);
        check_output("dut_pin_1001", int'(dut.u_table.pin_q[0]), 4242);
        apply_stimulus(1001, 4242);
        run_txn(3'b000, 1'b0, 0);
        end_session();
        apply_stimulus(1001, 1111);
        repeat (3) @(negedge clk);
        check_output("old_pin_fin", int'(ATM_Usage_Finished), 1);
        end_session();
        check_output("balance_pulses_total", cnt_bal, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
